// File: rtl/video_pkg.sv
// Shared raster timing defaults, VRAM geometry, colour types and pipeline flags.
// Constants only: no latency.
// No flow control: the video path free-runs at one pixel per clock.
package video_pkg;

    // Default 640x480 VGA raster timing.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Default placement of the upscaled VRAM image.
    localparam int DEF_SCALE    = 4;
    localparam int DEF_X_OFFSET = 64;
    localparam int DEF_Y_OFFSET = 112;

    // VRAM geometry.
    localparam int VRAM_W = 128;
    localparam int VRAM_H = 64;
    localparam int PIX_W  = 2;
    localparam int HPOS_W = $clog2(VRAM_W);
    localparam int VPOS_W = $clog2(VRAM_H);

    localparam int RGB_W  = 12;

    typedef logic [RGB_W-1:0] rgb_t;
    typedef logic [PIX_W-1:0] pix_t;

    localparam rgb_t DEF_BORDER = 12'h111;
    localparam rgb_t DEF_PAL0   = 12'h000;
    localparam rgb_t DEF_PAL1   = 12'h555;
    localparam rgb_t DEF_PAL2   = 12'hAAA;
    localparam rgb_t DEF_PAL3   = 12'hFFF;

    // Per-pixel control flags carried alongside the VRAM read.
    // Sync flags are active-high "asserted" so a cleared pipeline means idle sync.
    typedef struct packed {
        logic in_win;
        logic active;
        logic hsync_on;
        logic vsync_on;
        logic frame_start;
    } vid_flags_t;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/video_timing.sv
// Raster counters plus combinational active/sync/frame-start flags for the current position.
// Latency: flags are combinational from the registered counters.
// No backpressure: counters advance every clock.
module video_timing
    import video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          active,
    output logic          hsync_on,
    output logic          vsync_on,
    output logic          frame_start
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_LO  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_HI  = HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_LO  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_HI  = VW'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end else begin
            hcount <= hcount + 1'b1;
        end
    end

    always_comb begin
        active      = (hcount < H_ACT) && (vcount < V_ACT);
        hsync_on    = (hcount >= HS_LO) && (hcount < HS_HI);
        vsync_on    = (vcount >= VS_LO) && (vcount < VS_HI);
        // First blanking line start: the CPU timers tick once per frame here.
        frame_start = (hcount == '0) && (vcount == V_ACT);
    end

endmodule

// File: rtl/vram_scanout.sv
// Scans 128x64x2bpp VRAM, upscales by SCALE into a centred VGA window, palettes to RGB444.
// Latency: 2 clocks from raster counter to hsync/vsync/de/rgb/frame_tick, all aligned.
// No backpressure: free-running; VRAM read data must return one clock after the address.
module vram_scanout
    import video_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   SCALE    = DEF_SCALE,
    parameter int   X_OFFSET = DEF_X_OFFSET,
    parameter int   Y_OFFSET = DEF_Y_OFFSET,
    parameter rgb_t BORDER   = DEF_BORDER,
    parameter rgb_t PAL0     = DEF_PAL0,
    parameter rgb_t PAL1     = DEF_PAL1,
    parameter rgb_t PAL2     = DEF_PAL2,
    parameter rgb_t PAL3     = DEF_PAL3
) (
    input  logic              clk,
    input  logic              reset,
    output logic [HPOS_W-1:0] vram_rd_hpos,
    output logic [VPOS_W-1:0] vram_rd_vpos,
    input  logic [PIX_W-1:0]  vram_rd_pixel,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [RGB_W-1:0]  rgb,
    output logic              frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int SHIFT   = $clog2(SCALE);

    localparam logic [HW-1:0] X_LO = HW'(X_OFFSET);
    localparam logic [HW-1:0] X_HI = HW'(X_OFFSET + VRAM_W * SCALE);
    localparam logic [VW-1:0] Y_LO = VW'(Y_OFFSET);
    localparam logic [VW-1:0] Y_HI = VW'(Y_OFFSET + VRAM_H * SCALE);

    if (!is_pow2(SCALE)) begin : g_scale_check
        $error("vram_scanout: SCALE must be a power of two");
    end

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          active;
    logic          hsync_on;
    logic          vsync_on;
    logic          frame_start;

    video_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .active      (active),
        .hsync_on    (hsync_on),
        .vsync_on    (vsync_on),
        .frame_start (frame_start)
    );

    // ------------------------------------------------------------------
    // Stage 0: window test and VRAM address from the raster position
    // ------------------------------------------------------------------
    logic              in_win;
    logic [HW-1:0]     hrel;
    logic [VW-1:0]     vrel;
    logic [HPOS_W-1:0] hpos_nxt;
    logic [VPOS_W-1:0] vpos_nxt;
    vid_flags_t        s0_flags;
    vid_flags_t        s1_flags;

    always_comb begin
        in_win   = (hcount >= X_LO) && (hcount < X_HI) &&
                   (vcount >= Y_LO) && (vcount < Y_HI);
        hrel     = hcount - X_LO;
        vrel     = vcount - Y_LO;
        // SCALE is a power of two, so the downscale is a plain shift.
        hpos_nxt = '0;
        vpos_nxt = '0;
        if (in_win) begin
            hpos_nxt = HPOS_W'(hrel >> SHIFT);
            vpos_nxt = VPOS_W'(vrel >> SHIFT);
        end

        s0_flags             = '0;
        s0_flags.in_win      = in_win;
        s0_flags.active      = active;
        s0_flags.hsync_on    = hsync_on;
        s0_flags.vsync_on    = vsync_on;
        s0_flags.frame_start = frame_start;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vram_rd_hpos <= '0;
            vram_rd_vpos <= '0;
            s1_flags     <= '0;
        end else begin
            vram_rd_hpos <= hpos_nxt;
            vram_rd_vpos <= vpos_nxt;
            s1_flags     <= s0_flags;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: VRAM pixel is back; palette and border select
    // ------------------------------------------------------------------
    rgb_t pal_rgb;
    rgb_t rgb_nxt;

    always_comb begin
        pal_rgb = PAL0;
        case (vram_rd_pixel)
            2'd0:    pal_rgb = PAL0;
            2'd1:    pal_rgb = PAL1;
            2'd2:    pal_rgb = PAL2;
            default: pal_rgb = PAL3;
        endcase

        rgb_nxt = '0;
        if (s1_flags.in_win) begin
            rgb_nxt = pal_rgb;
        end else if (s1_flags.active) begin
            rgb_nxt = BORDER;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: registered pins
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            de         <= 1'b0;
            rgb        <= '0;
            frame_tick <= 1'b0;
        end else begin
            hsync      <= ~s1_flags.hsync_on;
            vsync      <= ~s1_flags.vsync_on;
            de         <= s1_flags.active;
            rgb        <= rgb_nxt;
            frame_tick <= s1_flags.frame_start;
        end
    end

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout on a shrunk raster (SCALE 2) so two full frames stay short.
module tb_vram_scanout;

    localparam int HA = 264, HF = 2, HS = 4, HB = 2;
    localparam int VA = 132, VF = 1, VS = 2, VB = 1;
    localparam int SC = 2, XO = 4, YO = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  vram_rd_hpos;
    logic [5:0]  vram_rd_vpos;
    logic [1:0]  vram_rd_pixel;
    logic        hsync, vsync, de, frame_tick;
    logic [11:0] rgb;

    always #5 clk = ~clk;

    logic [1:0] vram [0:63][0:127];
    assign vram_rd_pixel = vram[vram_rd_vpos][vram_rd_hpos];

    vram_scanout #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SCALE (SC), .X_OFFSET (XO), .Y_OFFSET (YO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .vram_rd_hpos  (vram_rd_hpos),
        .vram_rd_vpos  (vram_rd_vpos),
        .vram_rd_pixel (vram_rd_pixel),
        .hsync         (hsync),
        .vsync         (vsync),
        .de            (de),
        .rgb           (rgb),
        .frame_tick    (frame_tick)
    );

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] rgb;
        logic        ft;
    } obs_t;

    typedef struct packed {
        logic [6:0] hpos;
        logic [5:0] vpos;
    } addr_t;

    typedef struct {
        int          line;
        int          col;
        logic        de;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } vec_t;

    typedef struct {
        int         line;
        int         col;
        logic [6:0] hpos;
        logic [5:0] vpos;
    } avec_t;

    localparam obs_t RST_OBS = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 12'h000, ft: 1'b0};

    vec_t  vtab[$];
    avec_t atab[$];
    obs_t  sb[$];
    int    tick_t[$];
    int    checks = 0;
    int    passed = 0;
    int    t = 0;
    bit    tick_phase = 1'b0;
    int    de_cnt = 0, hs_low = 0, vs_low = 0;

    function automatic logic [11:0] pal(input logic [1:0] p);
        case (p)
            2'd0:    return 12'h000;
            2'd1:    return 12'h555;
            2'd2:    return 12'hAAA;
            default: return 12'hFFF;
        endcase
    endfunction

    function automatic obs_t model(input int tt);
        int   h, v;
        logic act, win;
        obs_t o;
        h = tt % HT;
        v = (tt / HT) % VT;
        act = (h < HA) && (v < VA);
        win = (h >= XO) && (h < XO + 128 * SC) && (v >= YO) && (v < YO + 64 * SC);
        o.hs = !((h >= HA + HF) && (h < HA + HF + HS));
        o.vs = !((v >= VA + VF) && (v < VA + VF + VS));
        o.de = act;
        o.ft = (h == 0) && (v == VA);
        if (win)      o.rgb = pal(vram[(v - YO) / SC][(h - XO) / SC]);
        else if (act) o.rgb = 12'h111;
        else          o.rgb = 12'h000;
        return o;
    endfunction

    function automatic addr_t amodel(input int tt);
        int    h, v;
        addr_t a;
        h = tt % HT;
        v = (tt / HT) % VT;
        a = '0;
        if ((h >= XO) && (h < XO + 128 * SC) && (v >= YO) && (v < YO + 64 * SC)) begin
            a.hpos = 7'((h - XO) / SC);
            a.vpos = 6'((v - YO) / SC);
        end
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s t=%0d got=%0h exp=%0h", name, t, got, exp);
    endtask

    task automatic addv(input int l, input int c, input logic d, input logic h,
                        input logic v, input logic [11:0] r);
        vtab.push_back('{l, c, d, h, v, r});
    endtask

    task automatic adda(input int l, input int c, input logic [6:0] hp, input logic [5:0] vp);
        atab.push_back('{l, c, hp, vp});
    endtask

    // Called once per cycle at the falling edge; t is the cycle index since reset release.
    task automatic monitor();
        obs_t  got, exp;
        addr_t ga, ea;
        int    p;
        got = '{hs: hsync, vs: vsync, de: de, rgb: rgb, ft: frame_tick};
        ga  = '{hpos: vram_rd_hpos, vpos: vram_rd_vpos};
        sb.push_back(model(t));
        exp = sb.pop_front();
        check("pipe", 32'(got), 32'(exp));
        ea = (t == 0) ? addr_t'(0) : amodel(t - 1);
        check("addr", 32'(ga), 32'(ea));
        if (t >= 2 && t - 2 < FRAME) begin
            p = t - 2;
            foreach (vtab[i])
                if (vtab[i].line == p / HT && vtab[i].col == p % HT)
                    check($sformatf("tbl%0d", i), 32'({de, hsync, vsync, rgb}),
                          32'({vtab[i].de, vtab[i].hs, vtab[i].vs, vtab[i].rgb}));
        end
        if (t >= 1 && t - 1 < FRAME) begin
            p = t - 1;
            foreach (atab[i])
                if (atab[i].line == p / HT && atab[i].col == p % HT)
                    check($sformatf("atbl%0d", i), 32'(ga), 32'({atab[i].hpos, atab[i].vpos}));
        end
        if (tick_phase && frame_tick) tick_t.push_back(t);
        if (tick_phase && t >= 2 && t < 2 + FRAME) begin
            if (de)     de_cnt++;
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
        end
    endtask

    task automatic release_reset();
        reset = 1'b0;
        t = 0;
        sb.delete();
        sb.push_back(RST_OBS);
        sb.push_back(RST_OBS);
        monitor();
    endtask

    initial begin
        int r_at;
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 128; x++)
                vram[y][x] = (y >= 10 && y <= 60) ? 2'($urandom_range(3, 0)) : 2'd0;
        vram[0][0]   = 2'd3;
        vram[63][127] = 2'd1;
        vram[1][5]   = 2'd2;

        // line, col, de, hsync, vsync, rgb (at the pins, for that raster position)
        addv(2, 4, 1, 1, 1, 12'hFFF);    addv(2, 5, 1, 1, 1, 12'hFFF);
        addv(2, 6, 1, 1, 1, 12'h000);    addv(3, 4, 1, 1, 1, 12'hFFF);
        addv(4, 4, 1, 1, 1, 12'h000);    addv(129, 258, 1, 1, 1, 12'h555);
        addv(128, 259, 1, 1, 1, 12'h555); addv(4, 14, 1, 1, 1, 12'hAAA);
        addv(5, 15, 1, 1, 1, 12'hAAA);   addv(4, 16, 1, 1, 1, 12'h000);
        addv(2, 3, 1, 1, 1, 12'h111);    addv(1, 100, 1, 1, 1, 12'h111);
        addv(130, 100, 1, 1, 1, 12'h111); addv(100, 260, 1, 1, 1, 12'h111);
        addv(100, 263, 1, 1, 1, 12'h111); addv(10, 264, 0, 1, 1, 12'h000);
        addv(10, 265, 0, 1, 1, 12'h000); addv(10, 266, 0, 0, 1, 12'h000);
        addv(10, 269, 0, 0, 1, 12'h000); addv(10, 270, 0, 1, 1, 12'h000);
        addv(132, 0, 0, 1, 1, 12'h000);  addv(133, 0, 0, 1, 0, 12'h000);
        addv(134, 5, 0, 1, 0, 12'h000);  addv(135, 0, 0, 1, 1, 12'h000);

        // line, col, hpos, vpos (address registered from that raster position)
        adda(2, 4, 7'd0, 6'd0);     adda(2, 5, 7'd0, 6'd0);
        adda(2, 6, 7'd1, 6'd0);     adda(2, 259, 7'd127, 6'd0);
        adda(2, 260, 7'd0, 6'd0);   adda(4, 4, 7'd0, 6'd1);
        adda(129, 258, 7'd127, 6'd63); adda(1, 100, 7'd0, 6'd0);
        adda(130, 100, 7'd0, 6'd0); adda(6, 10, 7'd3, 6'd2);

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out", 32'({hsync, vsync, de, rgb, frame_tick}), 32'(RST_OBS));
        check("rst_addr", 32'({vram_rd_hpos, vram_rd_vpos}), 32'd0);

        tick_phase = 1'b1;
        release_reset();
        // Two full frames, then into the third frame at line 10, column 100.
        r_at = 2 * FRAME + 10 * HT + 100;
        for (int i = 1; i <= r_at; i++) begin
            @(negedge clk);
            t = i;
            monitor();
        end
        tick_phase = 1'b0;

        check("tick_cnt", 32'(tick_t.size()), 32'd2);
        if (tick_t.size() >= 1) check("tick_first", 32'(tick_t[0]), 32'(VA * HT + 2));
        if (tick_t.size() >= 2) check("tick_gap", 32'(tick_t[1] - tick_t[0]), 32'(FRAME));
        check("de_count", 32'(de_cnt), 32'(HA * VA));
        check("hs_low", 32'(hs_low), 32'(HS * VT));
        check("vs_low", 32'(vs_low), 32'(VS * HT));

        // Mid-frame reset for one clock inside the picture window.
        check("pre_rst_de", 32'(de), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_out", 32'({hsync, vsync, de, rgb, frame_tick}), 32'(RST_OBS));
        check("mid_rst_addr", 32'({vram_rd_hpos, vram_rd_vpos}), 32'd0);
        release_reset();
        for (int i = 1; i <= 3 * HT; i++) begin
            @(negedge clk);
            t = i;
            monitor();
            if (t == 1) check("de_after_rst_t1", 32'(de), 32'd0);
            if (t == 2) check("de_after_rst_t2", 32'(de), 32'd1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
